// File: rtl/exibe_sequencia.sv
// -----------------------------------------------------------------------------
// exibe_sequencia
//   Plays back a sequence of 4-bit values read from an external synchronous
//   16x4 ROM. Each value is lit on leds for T_ON cycles and then blanked for
//   T_OFF cycles. The sequence runs from address 0 up to the limit that was
//   captured at start.
//
// Parameters
//   T_ON       cycles each value stays lit (1..4095)
//   T_OFF      blank cycles after each value (1..4095)
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous reset, active low
//   iniciar    start request, honoured only while idle
//   parar      synchronous abort, honoured in every state
//   limite     index of the last ROM entry to show
//   dado       ROM data, valid one cycle after endereco changes
//   endereco   ROM address
//   leds       value shown to the player (0 = blank)
//   exibindo   high whenever a run is in progress (not idle)
//   pronto     one-cycle completion pulse
//   db_estado  current state encoding, for debug
// -----------------------------------------------------------------------------
module exibe_sequencia #(
  parameter int unsigned T_ON  = 1000,
  parameter int unsigned T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] ESPERA_ROM = 3'd1;
  localparam logic [2:0] ACESO      = 3'd2;
  localparam logic [2:0] APAGADO    = 3'd3;
  localparam logic [2:0] FIM        = 3'd4;

  localparam logic [11:0] ON_LAST  = 12'(T_ON - 1);
  localparam logic [11:0] OFF_LAST = 12'(T_OFF - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [11:0] r_cnt;
  logic [3:0]  r_lim;
  logic [3:0]  r_end;
  logic [3:0]  r_leds;
  logic        w_on_done;
  logic        w_off_done;
  logic        w_timed;

  assign w_on_done  = (r_state == ACESO)   && (r_cnt == ON_LAST);
  assign w_off_done = (r_state == APAGADO) && (r_cnt == OFF_LAST);
  assign w_timed    = (r_state == ACESO) || (r_state == APAGADO);

  always_comb begin
    w_next = r_state;
    if (parar) begin
      w_next = OCIOSO;
    end else begin
      case (r_state)
        OCIOSO:     if (iniciar) w_next = ESPERA_ROM;
        ESPERA_ROM: w_next = ACESO;
        ACESO:      if (w_on_done) w_next = APAGADO;
        APAGADO:    if (w_off_done) w_next = (r_end == r_lim) ? FIM : ESPERA_ROM;
        FIM:        w_next = OCIOSO;
        default:    w_next = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= OCIOSO;
      r_cnt   <= '0;
      r_lim   <= '0;
      r_end   <= '0;
      r_leds  <= '0;
    end else begin
      r_state <= w_next;

      // Counter only runs inside the timed states and restarts on any change.
      if ((w_next != r_state) || !w_timed) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + 12'd1;

      if (parar) begin
        r_end <= '0;
      end else if ((r_state == OCIOSO) && iniciar) begin
        r_lim <= limite;
        r_end <= '0;
      end else if (w_off_done && (r_end != r_lim)) begin
        r_end <= r_end + 4'd1;
      end

      // The ROM answers one cycle after the address settles, so leds samples
      // dado while in ACESO; the display therefore trails the state by a cycle.
      r_leds <= (!parar && (r_state == ACESO)) ? dado : '0;
    end
  end

  assign endereco  = r_end;
  assign leds      = r_leds;
  assign exibindo  = (r_state != OCIOSO);
  assign pronto    = (r_state == FIM);
  assign db_estado = r_state;

endmodule

// File: tb/tb_exibe_sequencia.sv
module tb_exibe_sequencia;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic [3:0] limite;
  logic [3:0] dado = 4'd0;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  exibe_sequencia #(.T_ON(3), .T_OFF(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .parar     (parar),
    .limite    (limite),
    .dado      (dado),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // External synchronous ROM
  always @(posedge clock) dado <= mem[endereco];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int ld, input int en,
                         input int ex, input int pr, input bit en_chk);
    chk({tag, " estado"},   {5'd0, db_estado}, 8'(st));
    chk({tag, " leds"},     {4'd0, leds},      8'(ld));
    chk({tag, " exibindo"}, {7'd0, exibindo},  8'(ex));
    chk({tag, " pronto"},   {7'd0, pronto},    8'(pr));
    if (en_chk) chk({tag, " endereco"}, {4'd0, endereco}, 8'(en));
  endtask

  // Must be called right after edge E0 (the edge that sampled iniciar).
  // Each value occupies 6 cycles: ESPERA, ACESO x3, APAGADO x2; leds trails
  // the state by one cycle.
  task automatic run_profile(input string tag, input int lim, input int kmax, input bit poke);
    int last;
    int v;
    int ph;
    int st;
    int ld;
    last = 6 * (lim + 1);
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) step();
      if (k < last) begin
        v  = k / 6;
        ph = k % 6;
        st = (ph == 0) ? 1 : ((ph <= 3) ? 2 : 3);
        ld = (ph >= 2 && ph <= 4) ? int'(mem[v]) : 0;
        chk_all($sformatf("%s k=%0d", tag, k), st, ld, v, 1, 0, 1'b1);
      end else if (k == last) begin
        chk_all($sformatf("%s k=%0d", tag, k), 4, 0, lim, 1, 1, 1'b1);
      end else begin
        chk_all($sformatf("%s k=%0d", tag, k), 0, 0, 0, 0, 0, 1'b0);
      end
      if (poke) begin
        if (k == 2) begin iniciar = 1'b1; limite = 4'd15; end
        if (k == 3) iniciar = 1'b0;
      end
    end
  endtask

  task automatic start(input logic [3:0] lim);
    limite  = lim;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  initial begin
    mem[0] = 4'd1;
    mem[1] = 4'd2;
    mem[2] = 4'd4;
    for (int unsigned i = 3; i < 16; i++) mem[i] = 4'(i);

    reset   = 1'b0;
    iniciar = 1'b0;
    parar   = 1'b0;
    limite  = 4'd0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 1'b1);
    #11 reset = 1'b1;
    step();
    chk_all("idle", 0, 0, 0, 0, 0, 1'b1);

    // single value
    start(4'd0);
    run_profile("single", 0, 7, 1'b0);

    // three values
    step();
    start(4'd2);
    run_profile("three", 2, 19, 1'b0);

    // abort during the second ACESO cycle of the second value
    step();
    start(4'd2);
    run_profile("abort_pre", 2, 8, 1'b0);
    parar = 1'b1;
    step();
    parar = 1'b0;
    chk_all("abort", 0, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all($sformatf("abort_after k=%0d", k), 0, 0, 0, 0, 0, 1'b1);
    end

    // asynchronous reset during APAGADO of the second value
    start(4'd2);
    run_profile("rst_pre", 2, 10, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0, 1'b1);
    step();
    reset = 1'b1;
    step();
    chk_all("rst_wait", 0, 0, 0, 0, 0, 1'b1);
    step();
    chk_all("rst_wait2", 0, 0, 0, 0, 0, 1'b1);
    start(4'd0);
    run_profile("rst_restart", 0, 7, 1'b0);

    // iniciar during ACESO and limite changed mid-run are ignored
    step();
    start(4'd1);
    run_profile("ignore", 1, 13, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all($sformatf("ignore_after k=%0d", k), 0, 0, 0, 0, 0, 1'b0);
    end

    // boundary: last address 15, no wrap
    start(4'd15);
    run_profile("lim15", 15, 97, 1'b0);

    // parar wins over iniciar while idle
    limite  = 4'd3;
    iniciar = 1'b1;
    parar   = 1'b1;
    step();
    chk_all("both", 0, 0, 0, 0, 0, 1'b1);
    step();
    chk_all("both2", 0, 0, 0, 0, 0, 1'b1);
    iniciar = 1'b0;
    parar   = 1'b0;
    step();
    chk_all("both3", 0, 0, 0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 The block SHALL have parameter T_ON, default 1000, meaning the number of clock cycles each sequence value is lit (legal range 1..4095).
REQ-002 The block SHALL have parameter T_OFF, default 500, meaning the number of blank clock cycles after each value (legal range 1..4095).
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request, sampled only in OCIOSO.
- parar  in  1  synchronous abort, acts in any state.
- limite  in  4  index of the last ROM entry to show (0..15).
- dado  in  4  data from the external sync_rom_16x4; it is valid one cycle after endereco changes.
- endereco  out  4  ROM address.
- leds  out  4  value presented to the player; 0 means blank.
- exibindo  out  1  high in every state except OCIOSO.
- pronto  out  1  one-cycle completion pulse.
- db_estado  out  3  state encoding for debug.

Function
REQ-004 The block SHALL implement the states OCIOSO, ESPERA_ROM, ACESO, APAGADO and FIM.
REQ-005 OCIOSO: on iniciar=1, the block SHALL capture limite into an internal register, set endereco=0, and go to ESPERA_ROM; otherwise it SHALL stay in OCIOSO.
REQ-006 ESPERA_ROM SHALL last exactly 1 cycle, keep leds=0, then go to ACESO.
REQ-007 On entry to ACESO, leds SHALL be loaded with dado (a registered value), and that value SHALL be held for exactly T_ON cycles.
REQ-008 After ACESO, the block SHALL enter APAGADO with leds=0 for exactly T_OFF cycles.
REQ-009 At the end of APAGADO:
- If endereco equals the captured limite, the block SHALL go to FIM.
- Otherwise it SHALL increment endereco by 1 and go to ESPERA_ROM.
REQ-010 FIM SHALL last 1 cycle with pronto=1, then go to OCIOSO.
REQ-011 pronto SHALL be 1 only in FIM.
REQ-012 exibindo SHALL be 1 in ESPERA_ROM, ACESO, APAGADO and FIM.
REQ-013 A single 12-bit duration counter SHALL time ACESO and APAGADO, and SHALL be cleared on each state change.
REQ-014 endereco SHALL never wrap, because limite is at most 15.
REQ-015 The captured limite SHALL be used for the whole run; changes on limite mid-run SHALL have no effect.
REQ-016 iniciar SHALL be ignored outside OCIOSO.
REQ-017 parar=1 in any state SHALL return the block to OCIOSO on the next edge with leds=0 and endereco=0, and SHALL NOT produce a pronto pulse.
REQ-018 If parar and iniciar are both 1 in OCIOSO, parar SHALL win and the block SHALL stay in OCIOSO.
REQ-019 Timing: with iniciar sampled at edge E0, leds SHALL show mem[0] from edge E0+2, and pronto SHALL be high in the cycle following edge E0+(limite+1)*(1+T_ON+T_OFF).
REQ-020 db_estado encoding SHALL be: OCIOSO=0, ESPERA_ROM=1, ACESO=2, APAGADO=3, FIM=4.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for a clock edge, force OCIOSO, endereco=0, leds=0, exibindo=0, pronto=0, db_estado=0, the timer to 0 and the captured limite to 0.
REQ-022 Reset asserted mid-run SHALL abort the run with no pronto pulse.
REQ-023 After reset is released, the block SHALL wait for a new iniciar.

Verification (T_ON=3, T_OFF=2, ROM mem[0..2]=1,2,4)
REQ-024 Scenario "single value": limite=0, iniciar pulse at E0 -> leds=1 during cycles E0+2..E0+4, then 0; pronto pulse after E0+6; exibindo falls after E0+7.
REQ-025 Scenario "three values": limite=2 -> leds sequence 1,2,4 (each for 3 cycles, 2-cycle gaps, 1 blank ESPERA_ROM cycle before each); endereco goes 0,1,2; pronto after E0+18.
REQ-026 Scenario "abort": limite=2, parar at the second ACESO cycle of value 2 -> next edge OCIOSO, leds=0, endereco=0, pronto never asserted.
REQ-027 Scenario "reset mid-run": reset=0 asynchronously during APAGADO -> all outputs 0 before the next edge; a subsequent iniciar restarts from endereco=0.
REQ-028 Scenario "ignored inputs": iniciar pulsed during ACESO, and limite changed to 15 mid-run with captured limite=1 -> run ends after endereco=1 with a single pronto pulse.
REQ-029 Scenario "boundary": limite=15 -> endereco reaches 15 without wrapping, then FIM; iniciar and parar both high in OCIOSO -> block stays in OCIOSO.
